// File: rtl/UART_pkg.sv
// UART_pkg: shared UART state encodings for the receiver, transmitter and tx arbiter.
package UART_pkg;

   typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} arb_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin search, first valid index above last_grant with wrap.
module rr_pick #(
   parameter int N = 3,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] valid,
   input  logic [W-1:0] last_grant,
   output logic [W-1:0] win,
   output logic         any_valid
);

   logic [W-1:0] idx;

   // scan from farthest to nearest so the nearest valid index is written last
   always_comb begin
      win = '0;
      idx = '0;
      for (int i = N; i >= 1; i--) begin
         idx = W'((int'(last_grant) + i) % N);
         if (valid[idx]) win = idx;
      end
   end

   assign any_valid = |valid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NUM_REQ byte sources,
// with a busy-rise watchdog that raises a sticky err_timeout.
module uart_tx_arbiter
   import UART_pkg::*;
#(
   parameter int NUM_REQ      = 3,
   parameter int BUSY_TIMEOUT = 16,
   localparam int GW = $clog2(NUM_REQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ-1:0][7:0] req_data,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic [7:0]              Tx_Data,
   output logic                    tx_send,
   input  logic                    tx_busy,
   output logic [GW-1:0]           grant_id,
   output logic                    err_timeout,
   output arb_state_t              Arb_state_out
);

   localparam int CW = $clog2(BUSY_TIMEOUT + 1);

   arb_state_t    state;
   logic [GW-1:0] last_grant;
   logic [GW-1:0] win;
   logic          any;
   logic [CW-1:0] cnt;
   logic          accept;

   rr_pick #(.N(NUM_REQ)) u_pick (
      .valid      (req_valid),
      .last_grant (last_grant),
      .win        (win),
      .any_valid  (any)
   );

   // rst gates the grant so req_ready is low for the whole reset interval
   assign accept = rst && state == IDLE && any && !tx_busy;

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[win] = 1'b1;
   end

   assign Arb_state_out = state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         tx_send     <= 1'b0;
         Tx_Data     <= 8'h00;
         grant_id    <= '0;
         last_grant  <= GW'(NUM_REQ - 1);
         err_timeout <= 1'b0;
         cnt         <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               Tx_Data    <= req_data[win];
               grant_id   <= win;
               last_grant <= win;
               tx_send    <= 1'b1;
               state      <= START;
            end
            START: begin
               tx_send <= 1'b0;
               cnt     <= '0;
               state   <= WAIT_BUSY;
            end
            WAIT_BUSY: if (tx_busy) begin
               cnt   <= '0;
               state <= WAIT_DONE;
            end else begin
               cnt <= (cnt == CW'(BUSY_TIMEOUT)) ? cnt : cnt + 1'b1;
               if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
                  err_timeout <= 1'b1;
                  state       <= IDLE;
               end
            end
            WAIT_DONE: if (!tx_busy) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: table vectors, hand-written corner sequences and a randomized
// run against a transaction-timing model of the arbiter.
module tb_uart_tx_arbiter;
   import UART_pkg::*;

   localparam int N = 3;
   localparam int T = 16;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0][7:0] req_data = '0;
   logic [N-1:0]    req_ready;
   logic [7:0]      Tx_Data;
   logic            tx_send;
   logic            tx_busy = 1'b0;
   logic [1:0]      grant_id;
   logic            err_timeout;
   arb_state_t      Arb_state_out;

   int vectors = 0;
   int miscompares = 0;

   uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(T)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_ready     (req_ready),
      .Tx_Data       (Tx_Data),
      .tx_send       (tx_send),
      .tx_busy       (tx_busy),
      .grant_id      (grant_id),
      .err_timeout   (err_timeout),
      .Arb_state_out (Arb_state_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] valid;
      logic [7:0] base;
      logic [2:0] exp_ready;
      int         exp_id;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 64; i++) begin
         if (Arb_state_out == IDLE) return;
         next_cycle();
      end
      chk("idle_wait_expired", 0, 1);
   endtask

   task automatic busy_frame(input int len);
      tx_busy = 1'b1;
      repeat (len) next_cycle();
      tx_busy = 1'b0;
      wait_idle();
   endtask

   task automatic run_vec(input vec_t v);
      req_valid = v.valid;
      for (int i = 0; i < N; i++) req_data[i] = v.base + 8'(i);
      tx_busy = 1'b0;
      #2 chk("tbl_ready", 32'(req_ready), 32'(v.exp_ready));
      next_cycle();
      req_valid = '0;
      #1;
      chk("tbl_tx_send", 32'(tx_send), 1);
      chk("tbl_tx_data", 32'(Tx_Data), 32'(8'(v.base + 8'(v.exp_id))));
      chk("tbl_grant_id", 32'(grant_id), v.exp_id);
      chk("tbl_ready_busy", 32'(req_ready), 0);
      next_cycle();
      #1 chk("tbl_send_pulse", 32'(tx_send), 0);
      next_cycle();
      busy_frame(3);
   endtask

   initial begin
      logic [2:0] vld;
      logic [7:0] dv[N];
      logic       busy_v, idle, to, exp_err;
      int         a, f, d, l, w, last, idx;
      logic [7:0] exp_byte;
      int         exp_gid;
      arb_state_t exp_state;

      tbl[0]  = '{3'b010, 8'hA4, 3'b010, 1};
      tbl[1]  = '{3'b111, 8'h10, 3'b100, 2};
      tbl[2]  = '{3'b111, 8'h20, 3'b001, 0};
      tbl[3]  = '{3'b111, 8'h30, 3'b010, 1};
      tbl[4]  = '{3'b101, 8'h40, 3'b100, 2};
      tbl[5]  = '{3'b101, 8'h50, 3'b001, 0};
      tbl[6]  = '{3'b101, 8'h60, 3'b100, 2};
      tbl[7]  = '{3'b011, 8'h70, 3'b001, 0};
      tbl[8]  = '{3'b011, 8'h80, 3'b010, 1};
      tbl[9]  = '{3'b001, 8'h90, 3'b001, 0};
      tbl[10] = '{3'b001, 8'hB0, 3'b001, 0};
      tbl[11] = '{3'b110, 8'hC0, 3'b010, 1};

      // reset held across edges with requests pending
      rst = 1'b0;
      req_valid = 3'b111;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_tx_send", 32'(tx_send), 0);
      chk("rst_tx_data", 32'(Tx_Data), 0);
      chk("rst_grant_id", 32'(grant_id), 0);
      chk("rst_err", 32'(err_timeout), 0);
      chk("rst_state", 32'(Arb_state_out), 32'(IDLE));
      req_valid = '0;
      rst = 1'b1;
      next_cycle();

      foreach (tbl[i]) run_vec(tbl[i]);

      // busy never rises: watchdog fires exactly T cycles into WAIT_BUSY
      req_valid = 3'b100;
      req_data[2] = 8'h5C;
      #2 chk("to_ready", 32'(req_ready), 32'(3'b100));
      next_cycle();
      req_valid = '0;
      #1 chk("to_tx_send", 32'(tx_send), 1);
      for (int k = 2; k <= T + 1; k++) begin
         next_cycle();
         #1;
         chk("to_err_early", 32'(err_timeout), 0);
         chk("to_state_wb", 32'(Arb_state_out), 32'(WAIT_BUSY));
      end
      next_cycle();
      #1;
      chk("to_err_set", 32'(err_timeout), 1);
      chk("to_state_idle", 32'(Arb_state_out), 32'(IDLE));
      req_valid = 3'b001;
      req_data[0] = 8'h77;
      #1 chk("to_next_ready", 32'(req_ready), 32'(3'b001));
      next_cycle();
      req_valid = '0;
      #1;
      chk("to_next_send", 32'(tx_send), 1);
      chk("to_next_data", 32'(Tx_Data), 32'h77);
      next_cycle();
      busy_frame(2);
      chk("to_err_sticky", 32'(err_timeout), 1);

      // async reset pulse during WAIT_DONE
      req_valid = 3'b010;
      req_data[1] = 8'hE1;
      next_cycle();
      req_valid = '0;
      next_cycle();
      tx_busy = 1'b1;
      next_cycle();
      #1 chk("mid_state_wd", 32'(Arb_state_out), 32'(WAIT_DONE));
      req_valid = 3'b111;
      rst = 1'b0;
      #1;
      chk("mid_state", 32'(Arb_state_out), 32'(IDLE));
      chk("mid_tx_send", 32'(tx_send), 0);
      chk("mid_tx_data", 32'(Tx_Data), 0);
      chk("mid_grant_id", 32'(grant_id), 0);
      chk("mid_err", 32'(err_timeout), 0);
      chk("mid_ready", 32'(req_ready), 0);
      #1 rst = 1'b1;
      tx_busy = 1'b0;
      #1 chk("mid_first_win", 32'(req_ready), 32'(3'b001));
      next_cycle();
      req_valid = '0;
      #1;
      chk("mid_grant0", 32'(grant_id), 0);
      chk("mid_send", 32'(tx_send), 1);
      next_cycle();
      busy_frame(2);

      // randomized run against transfer-timing model
      rst = 1'b0;
      next_cycle();
      rst = 1'b1;
      last = N - 1;
      exp_err = 1'b0;
      exp_byte = 8'h00;
      exp_gid = 0;
      a = -1;
      f = 0;
      to = 1'b0;
      d = 1;
      l = 1;
      for (int c = 0; c < 600; c++) begin
         idle = c >= f;
         busy_v = idle ? ($urandom_range(0, 7) == 0)
                       : (!to && c >= a + 1 + d && c < a + 1 + d + l);
         vld = 3'($urandom);
         for (int i = 0; i < N; i++) dv[i] = 8'($urandom);
         req_valid = vld;
         for (int i = 0; i < N; i++) req_data[i] = dv[i];
         tx_busy = busy_v;
         w = -1;
         if (idle && !busy_v)
            for (int k = 1; k <= N; k++) begin
               idx = (last + k) % N;
               if (w < 0 && vld[idx]) w = idx;
            end
         if (a >= 0 && to && c >= f) exp_err = 1'b1;
         exp_state = idle ? IDLE : (c == a + 1) ? START
                   : (to || c < a + 2 + d) ? WAIT_BUSY : WAIT_DONE;
         #2;
         chk("rnd_ready", 32'(req_ready), w >= 0 ? (32'd1 << w) : 32'd0);
         chk("rnd_tx_send", 32'(tx_send), 32'(a >= 0 && c == a + 1));
         chk("rnd_tx_data", 32'(Tx_Data), 32'(exp_byte));
         chk("rnd_grant_id", 32'(grant_id), exp_gid);
         chk("rnd_err", 32'(err_timeout), 32'(exp_err));
         chk("rnd_state", 32'(Arb_state_out), 32'(exp_state));
         if (w >= 0) begin
            a = c;
            last = w;
            exp_byte = dv[w];
            exp_gid = w;
            to = $urandom_range(0, 5) == 0;
            d = $urandom_range(1, 4);
            l = $urandom_range(1, 5);
            f = to ? c + 2 + T : c + 2 + d + l;
         end
         next_cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
